// File: rtl/taxi_rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package taxi_rst_seq_pkg;

    // Sequencer states: wait for all locks, count stable cycles, release channels.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK   = 2'd0,
        ST_STABLE      = 2'd1,
        ST_RELEASE_RUN = 2'd2
    } seq_state_e;

    localparam int              LOST_W   = 8;
    localparam logic [LOST_W-1:0] LOST_MAX = 8'hFF;

    // Counter width for a modulus n: $clog2(n), never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taxi_sync_signal.sv
// Multi-bit, multi-stage synchroniser with asynchronous active-low clear.
// Each bit is synchronised independently; no coherency between bits is implied.
module taxi_sync_signal #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync_q [DEPTH];

    // Shift chain: stage 0 captures the asynchronous input, the last stage is safe to use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[DEPTH-1];

endmodule

// File: rtl/taxi_rst_seq.sv
// Staged reset sequencer: waits for all clock-generator locks to be stable,
// then releases the output reset channels one by one in ascending order.
// Any lock loss or software reset while releasing puts every channel back
// into reset; lock losses during the release run are counted (saturating).
module taxi_rst_seq
    import taxi_rst_seq_pkg::*;
#(
    parameter int SYNC_N         = 4,
    parameter int LOCK_W         = 1,
    parameter int CH             = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LOCK_W-1:0] lock,
    input  logic              sw_rst,
    output logic [CH-1:0]     out,
    output logic              ready,
    output logic [LOST_W-1:0] lost_cnt
);

    localparam int STB_W = cnt_w(STABLE_CYCLES);
    localparam int STG_W = cnt_w(STAGGER_CYCLES);
    localparam int IDX_W = cnt_w(CH);

    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);
    localparam logic [CH-1:0]    ONE_CH   = CH'(1);
    localparam logic [CH-1:0]    ALL_ON   = {CH{1'b1}};

    logic [LOCK_W-1:0] lock_sync;
    logic              all_lock;

    seq_state_e        state_q, state_d;
    logic [STB_W-1:0]  stb_q, stb_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CH-1:0]     out_q, out_d;
    logic              ready_q, ready_d;
    logic [LOST_W-1:0] lost_q, lost_d;

    taxi_sync_signal #(
        .WIDTH (LOCK_W),
        .DEPTH (SYNC_N)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (lock),
        .data_o (lock_sync)
    );

    assign all_lock = &lock_sync;
    assign idx_nxt  = idx_q + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a lost lock or software reset always falls back to WAIT_LOCK.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (all_lock && !sw_rst) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!all_lock || sw_rst)  state_d = ST_WAIT_LOCK;
                else if (stb_q == STB_LAST) state_d = ST_RELEASE_RUN;
            end
            ST_RELEASE_RUN: begin
                if (!all_lock || sw_rst) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // Output and counter next values; out/ready are registered so they are glitch-free.
    always_comb begin
        stb_d   = '0;
        stg_d   = stg_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        lost_d  = lost_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                out_d   = ALL_ON;
                ready_d = 1'b0;
                stg_d   = '0;
                idx_d   = '0;
            end
            ST_STABLE: begin
                out_d   = ALL_ON;
                ready_d = 1'b0;
                stg_d   = '0;
                idx_d   = '0;
                if (state_d == ST_STABLE) begin
                    stb_d = stb_q + STB_W'(1);
                end else if (state_d == ST_RELEASE_RUN) begin
                    // Channel 0 leaves reset on the first cycle of the run.
                    out_d   = ALL_ON & ~ONE_CH;
                    ready_d = (CH == 1);
                end
            end
            ST_RELEASE_RUN: begin
                if (state_d == ST_WAIT_LOCK) begin
                    out_d   = ALL_ON;
                    ready_d = 1'b0;
                    stg_d   = '0;
                    idx_d   = '0;
                    // Only a real lock loss counts, even if sw_rst coincides.
                    if (!all_lock && (lost_q != LOST_MAX)) begin
                        lost_d = lost_q + 8'd1;
                    end
                end else if (idx_q != IDX_LAST) begin
                    if (stg_q == STG_LAST) begin
                        stg_d   = '0;
                        idx_d   = idx_nxt;
                        out_d   = out_q & ~(ONE_CH << idx_nxt);
                        ready_d = (idx_nxt == IDX_LAST);
                    end else begin
                        stg_d = stg_q + STG_W'(1);
                    end
                end
            end
            default: begin
                out_d   = ALL_ON;
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; out is forced to all ones the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q   <= '0;
            stg_q   <= '0;
            idx_q   <= '0;
            out_q   <= ALL_ON;
            ready_q <= 1'b0;
            lost_q  <= '0;
        end else begin
            stb_q   <= stb_d;
            stg_q   <= stg_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
        end
    end

    assign out      = out_q;
    assign ready    = ready_q;
    assign lost_cnt = lost_q;

endmodule
